// File: rtl/frame_buffer_reader_pkg.sv
// Shared constants, write-FSM encoding and address helper for the frame buffer.
package frame_buffer_reader_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOR_W  = 3;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 15;

  localparam logic [X_W-1:0]    X_LAST    = 8'd159;
  localparam logic [Y_W-1:0]    Y_LAST    = 7'd119;
  localparam logic [ADDR_W-1:0] ADDR_LAST = 15'd19199;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } wr_req_t;

  // y*160 + x built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] px,
                                                input logic [Y_W-1:0] py);
    logic [ADDR_W-1:0] ye;
    ye = {{(ADDR_W-Y_W){1'b0}}, py};
    return (ye << 7) + (ye << 5) + {{(ADDR_W-X_W){1'b0}}, px};
  endfunction

endpackage

// File: rtl/frame_buffer_reader_fb_ram.sv
// Simple dual-port frame store: one write port, one registered read port,
// read-before-write on address collision.
module fb_ram
  import frame_buffer_reader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [FB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reset maps onto the block RAM output-latch reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// Pixel-plot receiver with clear engine; streams the frame buffer out in
// raster order over a valid/ready pixel interface.
module frame_buffer_reader
  import frame_buffer_reader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [COLOR_W-1:0] colour,
  input  logic               plot,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_colour,
  output logic               busy,
  output logic               plot_err,
  input  logic               scan_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [X_W-1:0]     out_x,
  output logic [Y_W-1:0]     out_y,
  output logic [COLOR_W-1:0] out_colour,
  output logic               out_sof,
  output logic               out_eol
);

  wr_state_e          state;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [COLOR_W-1:0] clr_colour;
  logic               in_range;
  wr_req_t            wr;

  logic [X_W-1:0]     sx;
  logic [Y_W-1:0]     sy;
  logic               at_origin;
  logic               scan_act;
  logic               fetch_en;
  logic               rd_en;

  assign in_range = (x <= X_LAST) && (y <= Y_LAST);

  // ---------------- write side ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_colour <= '0;
      busy       <= 1'b0;
      plot_err   <= 1'b0;
    end else begin
      plot_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clr_colour <= clear_colour;
            busy       <= 1'b1;
            plot_err   <= plot;
          end else begin
            plot_err <= plot && !in_range;
          end
        end
        CLEAR: begin
          plot_err <= plot;
          if (clr_cnt == ADDR_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear owns the write port; a plot coinciding with clear_req is dropped.
  always_comb begin
    wr = '0;
    if (!reset) begin
      if (state == CLEAR) begin
        wr.we   = 1'b1;
        wr.addr = clr_cnt;
        wr.data = clr_colour;
      end else if (plot && in_range && !clear_req) begin
        wr.we   = 1'b1;
        wr.addr = fb_addr(x, y);
        wr.data = colour;
      end
    end
  end

  // ---------------- read side ----------------
  // scan_en only matters at the frame boundary; a started frame runs to the end.
  assign at_origin = (sx == '0) && (sy == '0);
  assign scan_act  = at_origin ? scan_en : 1'b1;
  assign fetch_en  = !out_valid || out_ready;
  assign rd_en     = fetch_en && scan_act && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      sx        <= '0;
      sy        <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (fetch_en) begin
      if (scan_act) begin
        out_valid <= 1'b1;
        out_x     <= sx;
        out_y     <= sy;
        out_sof   <= at_origin;
        out_eol   <= (sx == X_LAST);
        if (sx == X_LAST) begin
          sx <= '0;
          sy <= (sy == Y_LAST) ? '0 : sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
      end
    end
  end

  fb_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr.we),
    .waddr (wr.addr),
    .wdata (wr.data),
    .re    (rd_en),
    .raddr (fb_addr(sx, sy)),
    .rdata (out_colour)
  );

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench: expected raster pixels are queued from a reference frame
// model when a scan is launched and popped on every accepted output pixel.
module tb_frame_buffer_reader;
  import frame_buffer_reader_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [X_W-1:0]     x = '0;
  logic [Y_W-1:0]     y = '0;
  logic [COLOR_W-1:0] colour = '0;
  logic               plot = 1'b0;
  logic               clear_req = 1'b0;
  logic [COLOR_W-1:0] clear_colour = '0;
  logic               busy, plot_err;
  logic               scan_en = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [X_W-1:0]     out_x;
  logic [Y_W-1:0]     out_y;
  logic [COLOR_W-1:0] out_colour;
  logic               out_sof, out_eol;

  frame_buffer_reader dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_req(clear_req), .clear_colour(clear_colour), .busy(busy),
    .plot_err(plot_err), .scan_en(scan_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_colour(out_colour), .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [COLOR_W-1:0] model [FB_DEPTH];
  logic [19:0] exp_q [$];
  bit          sb_on = 1'b0;
  int          sof_cnt = 0;
  int          eol_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [19:0] snap_prev = '0;
  wire  [19:0] cur = {out_x, out_y, out_colour, out_sof, out_eol};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: stall stability plus in-order scoreboard compare.
  always @(negedge clk) begin
    if (sb_on) begin
      if (stall_prev) check("stall_hold", {11'b0, out_valid, cur}, {11'b0, 1'b1, snap_prev});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_pix", {12'b0, cur}, 32'hFFFF_FFFF);
        else                   check("pix", {12'b0, cur}, {12'b0, exp_q.pop_front()});
        if (out_sof) sof_cnt++;
        if (out_eol) eol_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      snap_prev  = cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_frame();
    for (int yy = 0; yy < V_RES; yy++)
      for (int xx = 0; xx < H_RES; xx++)
        exp_q.push_back({X_W'(xx), Y_W'(yy), model[yy*H_RES+xx],
                         (xx == 0 && yy == 0), (xx == H_RES-1)});
  endtask

  task automatic run_frame(input bit rnd);
    int cyc;
    push_frame();
    sof_cnt = 0;
    eol_cnt = 0;
    sb_on = 1'b1;
    out_ready = 1'b1;
    scan_en = 1'b1;
    step();
    scan_en = 1'b0;
    check("first_vld", out_valid, 1);
    check("first_xy", {out_x, out_y}, 0);
    check("first_sof", out_sof, 1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60000) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    check("frame_drained", exp_q.size(), 0);
    if (!rnd) check("frame_cycles", cyc, FB_DEPTH);
    check("sof_cnt", sof_cnt, 1);
    check("eol_cnt", eol_cnt, V_RES);
    out_ready = 1'b1;
    step();
    step();
    check("idle_after_frame", out_valid, 0);
    sb_on = 1'b0;
    exp_q.delete();
  endtask

  task automatic plot_px(input int px, input int py, input int pc, input bit exp_err);
    x = X_W'(px);
    y = Y_W'(py);
    colour = COLOR_W'(pc);
    plot = 1'b1;
    step();
    plot = 1'b0;
    check("plot_err", plot_err, exp_err);
    step();
    check("plot_err_pulse", plot_err, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_plot_err", plot_err, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sof_eol", {out_sof, out_eol}, 0);
    check("rst_xy", {out_x, out_y}, 0);
    check("rst_colour", out_colour, 0);
    reset = 1'b0;
    step();

    // clear to 010 with a colliding plot and a plot while busy, both dropped
    clear_colour = 3'b010;
    clear_req = 1'b1;
    plot = 1'b1; x = 8'd1; y = 7'd1; colour = 3'b111;
    step();
    clear_req = 1'b0;
    plot = 1'b0;
    check("busy_rise", busy, 1);
    check("plot_clr_err", plot_err, 1);
    plot = 1'b1; x = 8'd7; y = 7'd7; colour = 3'b101;
    step();
    plot = 1'b0;
    check("plot_busy_err", plot_err, 1);
    n = 1;
    while (busy && n < 20000) begin
      step();
      n++;
    end
    check("busy_len", n, FB_DEPTH);
    for (int i = 0; i < FB_DEPTH; i++) model[i] = 3'b010;

    run_frame(1'b0);

    plot_px(5, 3, 7, 1'b0);
    plot_px(159, 119, 1, 1'b0);
    plot_px(160, 0, 6, 1'b1);
    plot_px(0, 120, 6, 1'b1);
    model[3*H_RES+5]     = 3'b111;
    model[119*H_RES+159] = 3'b001;

    run_frame(1'b1);

    // reset in the middle of both a clear and a running frame
    clear_colour = 3'b100;
    clear_req = 1'b1;
    scan_en = 1'b1;
    out_ready = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (5000) step();
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_xy", {out_x, out_y}, 0);
    check("mid_rst_colour", out_colour, 0);
    reset = 1'b0;
    scan_en = 1'b1;
    out_ready = 1'b0;
    step();
    scan_en = 1'b0;
    check("restart_valid", out_valid, 1);
    check("restart_xy", {out_x, out_y}, 0);
    check("restart_sof", out_sof, 1);
    check("restart_colour", out_colour, 3'b100);
    check("restart_busy", busy, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
